// File: rtl/key_extractor.sv
// Per-stage key extractor: buffers one PHV, builds a 197b match key from a 16-entry program table.
// Define KEY_EXTRACT_STAT_EN to add the key_cnt / stall_cnt statistics outputs.
module key_extractor #(
    parameter int STAGE   = 0,
    parameter int PHV_LEN = 1124,
    parameter int KEY_LEN = 197,
    parameter int MIN_GAP = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PHV_LEN-1:0] phv_in,
    input  logic               phv_valid,
    output logic               phv_ready,
    output logic [KEY_LEN-1:0] extract_key,
    output logic               key_valid,
    output logic [PHV_LEN-1:0] phv_out,
    input  logic               cfg_en,
    input  logic [3:0]         cfg_addr,
    input  logic [127:0]       cfg_din
`ifdef KEY_EXTRACT_STAT_EN
    ,
    output logic [31:0]        key_cnt,
    output logic [31:0]        stall_cnt
`endif
);

    // The key layout is fixed; a negative stage index is meaningless.
    generate
        if (MIN_GAP < 1 || KEY_LEN != 197 || STAGE < 0) begin : g_bad_param
            $error("key_extractor: unsupported parameter set");
        end
    endgenerate

    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_GAP - 1);

    localparam logic [1:0] OP_EQ = 2'b00;
    localparam logic [1:0] OP_GT = 2'b01;
    localparam logic [1:0] OP_LT = 2'b10;

    logic [127:0]       prog_tbl [16];
    logic [PHV_LEN-1:0] phv_buf;
    logic               buf_valid;
    logic [GAP_W-1:0]   gap_cnt;
    logic               fire;
    logic               accept;
    logic [127:0]       entry;
    logic [47:0]        c48 [8];
    logic [31:0]        c32 [8];
    logic [15:0]        c16 [8];
    logic [4:0]         cond;
    logic [KEY_LEN-1:0] key_next;

    assign fire      = buf_valid && (gap_cnt == '0);
    assign phv_ready = !buf_valid || fire;
    assign accept    = phv_valid && phv_ready;

    // Key is built from the buffered PHV so it is ready on the fire edge.
    assign entry = prog_tbl[phv_buf[3:0]];

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_cont
            assign c48[g] = phv_buf[PHV_LEN-1-48*g   -: 48];
            assign c32[g] = phv_buf[PHV_LEN-385-32*g -: 32];
            assign c16[g] = phv_buf[PHV_LEN-641-16*g -: 16];
        end

        for (g = 0; g < 5; g++) begin : g_cond
            logic [21:0] cf;
            logic [15:0] operand;
            logic        hit;
            assign cf      = entry[18+22*g +: 22];
            assign operand = c16[cf[18:16]];
            assign hit     = (cf[20:19] == OP_EQ) ? (operand == cf[15:0]) :
                             (cf[20:19] == OP_GT) ? (operand >  cf[15:0]) :
                             (cf[20:19] == OP_LT) ? (operand <  cf[15:0]) :
                                                    (operand != cf[15:0]);
            assign cond[g] = cf[21] && hit;
        end
    endgenerate

    assign key_next = {c48[entry[2:0]],   c48[entry[5:3]],
                       c32[entry[8:6]],   c32[entry[11:9]],
                       c16[entry[14:12]], c16[entry[17:15]],
                       cond};

    // A fire on a write edge sees the old entry through the non-blocking update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                prog_tbl[i] <= '0;
            end
        end else if (cfg_en) begin
            prog_tbl[cfg_addr] <= cfg_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phv_buf   <= '0;
            buf_valid <= 1'b0;
        end else if (accept) begin
            phv_buf   <= phv_in;
            buf_valid <= 1'b1;
        end else if (fire) begin
            buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (fire) begin
            gap_cnt <= GAP_RELOAD;
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid   <= 1'b0;
            extract_key <= '0;
            phv_out     <= '0;
        end else begin
            key_valid <= fire;
            if (fire) begin
                extract_key <= key_next;
                phv_out     <= phv_buf;
            end
        end
    end

`ifdef KEY_EXTRACT_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (fire) begin
                key_cnt <= key_cnt + 32'd1;
            end
            if (phv_valid && !phv_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_key_extractor.sv
// Self-checking bench for key_extractor: scoreboard of expected keys/PHVs plus per-scenario timing checks.
// Build with KEY_EXTRACT_STAT_EN defined to also check the statistics counters.
module tb_key_extractor;

    localparam int PHV_LEN = 1124;
    localparam int KEY_LEN = 197;
    localparam int MIN_GAP = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [PHV_LEN-1:0] phv_in = '0;
    logic               phv_valid = 1'b0;
    logic               phv_ready;
    logic [KEY_LEN-1:0] extract_key;
    logic               key_valid;
    logic [PHV_LEN-1:0] phv_out;
    logic               cfg_en = 1'b0;
    logic [3:0]         cfg_addr = '0;
    logic [127:0]       cfg_din = '0;
`ifdef KEY_EXTRACT_STAT_EN
    logic [31:0]        key_cnt;
    logic [31:0]        stall_cnt;
`endif

    always #5 clk = ~clk;

    key_extractor #(
        .STAGE(0), .PHV_LEN(PHV_LEN), .KEY_LEN(KEY_LEN), .MIN_GAP(MIN_GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .phv_in(phv_in), .phv_valid(phv_valid), .phv_ready(phv_ready),
        .extract_key(extract_key), .key_valid(key_valid), .phv_out(phv_out),
        .cfg_en(cfg_en), .cfg_addr(cfg_addr), .cfg_din(cfg_din)
`ifdef KEY_EXTRACT_STAT_EN
        , .key_cnt(key_cnt), .stall_cnt(stall_cnt)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [127:0]       shadow [16];
    logic [KEY_LEN-1:0] exp_key_q [$];
    logic [PHV_LEN-1:0] exp_phv_q [$];
    int                 kv_cyc_q [$];
    logic [KEY_LEN-1:0] mon_ek;
    logic [PHV_LEN-1:0] mon_ep;

    always @(posedge clk) cyc++;

    // ---------------- reference model ----------------
    function automatic logic [47:0] get48(input logic [PHV_LEN-1:0] p, input int i);
        return p[PHV_LEN-1-48*i -: 48];
    endfunction
    function automatic logic [31:0] get32(input logic [PHV_LEN-1:0] p, input int i);
        return p[PHV_LEN-385-32*i -: 32];
    endfunction
    function automatic logic [15:0] get16(input logic [PHV_LEN-1:0] p, input int i);
        return p[PHV_LEN-641-16*i -: 16];
    endfunction
    function automatic logic [PHV_LEN-1:0] set48(input logic [PHV_LEN-1:0] p, input int i, input logic [47:0] v);
        p[PHV_LEN-1-48*i -: 48] = v;
        return p;
    endfunction
    function automatic logic [PHV_LEN-1:0] set32(input logic [PHV_LEN-1:0] p, input int i, input logic [31:0] v);
        p[PHV_LEN-385-32*i -: 32] = v;
        return p;
    endfunction
    function automatic logic [PHV_LEN-1:0] set16(input logic [PHV_LEN-1:0] p, input int i, input logic [15:0] v);
        p[PHV_LEN-641-16*i -: 16] = v;
        return p;
    endfunction
    function automatic logic [PHV_LEN-1:0] rand_phv(input logic [3:0] prog);
        logic [PHV_LEN-1:0] p;
        for (int i = 0; i < PHV_LEN; i++) p[i] = 1'($urandom_range(0, 1));
        p[3:0] = prog;
        return p;
    endfunction

    function automatic logic [KEY_LEN-1:0] model_key(input logic [PHV_LEN-1:0] p, input logic [127:0] e);
        logic [4:0]  c;
        logic [21:0] f;
        logic [15:0] v;
        for (int i = 0; i < 5; i++) begin
            f = e[18+22*i +: 22];
            v = get16(p, int'(f[18:16]));
            case (f[20:19])
                2'b00:   c[i] = (v == f[15:0]);
                2'b01:   c[i] = (v >  f[15:0]);
                2'b10:   c[i] = (v <  f[15:0]);
                default: c[i] = (v != f[15:0]);
            endcase
            if (!f[21]) c[i] = 1'b0;
        end
        return {get48(p, int'(e[2:0])), get48(p, int'(e[5:3])),
                get32(p, int'(e[8:6])), get32(p, int'(e[11:9])),
                get16(p, int'(e[14:12])), get16(p, int'(e[17:15])), c};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            kv_cyc_q.push_back(cyc);
            vectors++;
            if (exp_key_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: key_valid with empty scoreboard, key=%h", extract_key);
            end else begin
                mon_ek = exp_key_q.pop_front();
                mon_ep = exp_phv_q.pop_front();
                if (extract_key !== mon_ek) begin
                    miscompares++;
                    $display("FAIL sb_key: got %h exp %h", extract_key, mon_ek);
                end
                vectors++;
                if (phv_out !== mon_ep) begin
                    miscompares++;
                    $display("FAIL sb_phv: got low %h exp low %h", phv_out[127:0], mon_ep[127:0]);
                end
            end
        end
    end

    // ---------------- drivers (called and returning at negedge) ----------------
    task automatic step(input logic v, input logic [PHV_LEN-1:0] p,
                        input logic ce, input logic [3:0] ca, input logic [127:0] cd,
                        output logic acc, output logic stalled);
        phv_valid = v; phv_in = p; cfg_en = ce; cfg_addr = ca; cfg_din = cd;
        #1;
        acc     = v && phv_ready;
        stalled = v && !phv_ready;
        if (acc) begin
            exp_key_q.push_back(model_key(p, shadow[p[3:0]]));
            exp_phv_q.push_back(p);
        end
        if (ce) shadow[ca] = cd;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic a, s;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 4'd0, '0, a, s);
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [127:0] data);
        logic a, s;
        step(1'b0, '0, 1'b1, addr, data, a, s);
    endtask

    task automatic send(input logic [PHV_LEN-1:0] p, output logic ok, output int stalls);
        logic a, s;
        ok = 1'b0;
        stalls = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            step(1'b1, p, 1'b0, 4'd0, '0, a, s);
            ok = a;
            if (s) stalls++;
        end
    endtask

    task automatic wait_kv(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (key_valid === 1'b1) ok = 1'b1;
            else idle(1);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        phv_valid = 1'b0;
        cfg_en = 1'b0;
        exp_key_q.delete();
        exp_phv_q.delete();
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        vectors++;
        if (key_valid !== 1'b0) begin miscompares++; $display("FAIL rst_key_valid: got %b exp 0", key_valid); end
        vectors++;
        if (extract_key !== '0) begin miscompares++; $display("FAIL rst_key: got %h exp 0", extract_key); end
        vectors++;
        if (phv_out !== '0) begin miscompares++; $display("FAIL rst_phv_out: got low %h exp 0", phv_out[127:0]); end
        vectors++;
        if (phv_ready !== 1'b1) begin miscompares++; $display("FAIL rst_phv_ready: got %b exp 1", phv_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [PHV_LEN-1:0] p;
        logic [KEY_LEN-1:0] k;
        logic ok;
        int st;
        p = rand_phv(4'd0);
        p = set48(p, 0, 48'h112233445566);
        p = set32(p, 0, 32'hAABBCCDD);
        p = set16(p, 0, 16'h0800);
        k = {48'h112233445566, 48'h112233445566, 32'hAABBCCDD, 32'hAABBCCDD, 16'h0800, 16'h0800, 5'b0};
        send(p, ok, st);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL basic_accept: got not accepted exp accepted"); end
        vectors++;
        if (key_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early: key_valid got %b exp 0", key_valid); end
        idle(1);
        vectors++;
        if (key_valid !== 1'b1) begin miscompares++; $display("FAIL basic_latency: key_valid got %b exp 1", key_valid); end
        vectors++;
        if (extract_key !== k) begin miscompares++; $display("FAIL basic_key: got %h exp %h", extract_key, k); end
        idle(1);
        vectors++;
        if (key_valid !== 1'b0) begin miscompares++; $display("FAIL basic_pulse: key_valid got %b exp 0", key_valid); end
        vectors++;
        if (extract_key !== k || phv_out !== p) begin
            miscompares++; $display("FAIL basic_hold: key got %h exp %h", extract_key, k);
        end
    endtask

    task automatic test_select();
        logic [127:0] e;
        logic [PHV_LEN-1:0] p;
        logic ok;
        int st;
        e = '0;
        e[2:0] = 3'd2;
        e[17:15] = 3'd5;
        e[18 +: 22] = {1'b1, 2'b00, 3'd1, 16'h0800};
        cfg_write(4'd3, e);
        p = rand_phv(4'd3);
        p = set48(p, 2, 48'hA1A2A3A4A5A6);
        p = set16(p, 5, 16'hBEEF);
        p = set16(p, 1, 16'h0800);
        send(p, ok, st);
        wait_kv(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL sel_timeout: got no key_valid exp key_valid"); end
        vectors++;
        if (extract_key[196:149] !== 48'hA1A2A3A4A5A6) begin
            miscompares++; $display("FAIL sel_48a: got %h exp a1a2a3a4a5a6", extract_key[196:149]);
        end
        vectors++;
        if (extract_key[20:5] !== 16'hBEEF) begin
            miscompares++; $display("FAIL sel_16b: got %h exp beef", extract_key[20:5]);
        end
        vectors++;
        if (extract_key[4:0] !== 5'b00001) begin
            miscompares++; $display("FAIL sel_cond: got %b exp 00001", extract_key[4:0]);
        end
        idle(1);
    endtask

    task automatic test_conditions();
        logic [127:0] e;
        logic [PHV_LEN-1:0] p;
        logic ok;
        int st;
        e = '0;
        for (int i = 0; i < 4; i++) e[18+22*i +: 22] = {1'b1, 2'(i), 3'd0, 16'h0100};
        e[18+22*4 +: 22] = {1'b0, 2'b00, 3'd0, 16'h0100};
        cfg_write(4'd4, e);
        p = rand_phv(4'd4);
        p = set16(p, 0, 16'h0100);
        send(p, ok, st);
        wait_kv(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL cond_timeout: got no key_valid exp key_valid"); end
        vectors++;
        if (extract_key[4:0] !== 5'b00001) begin
            miscompares++; $display("FAIL cond_bits: got %b exp 00001", extract_key[4:0]);
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic ok;
        int st, total_st;
        logic [PHV_LEN-1:0] p;
`ifdef KEY_EXTRACT_STAT_EN
        logic [31:0] kc0, sc0;
`endif
        idle(6);
        kv_cyc_q.delete();
`ifdef KEY_EXTRACT_STAT_EN
        kc0 = key_cnt;
        sc0 = stall_cnt;
`endif
        total_st = 0;
        for (int i = 0; i < 3; i++) begin
            p = rand_phv(4'(i));
            send(p, ok, st);
            total_st += st;
            vectors++;
            if (!ok) begin miscompares++; $display("FAIL b2b_accept%0d: got not accepted exp accepted", i); end
        end
        for (int i = 0; i < 20 && kv_cyc_q.size() < 3; i++) idle(1);
        vectors++;
        if (kv_cyc_q.size() != 3) begin
            miscompares++; $display("FAIL b2b_count: got %0d keys exp 3", kv_cyc_q.size());
        end else begin
            vectors++;
            if (kv_cyc_q[1] - kv_cyc_q[0] != MIN_GAP || kv_cyc_q[2] - kv_cyc_q[1] != MIN_GAP) begin
                miscompares++;
                $display("FAIL b2b_spacing: got %0d,%0d exp %0d,%0d",
                         kv_cyc_q[1] - kv_cyc_q[0], kv_cyc_q[2] - kv_cyc_q[1], MIN_GAP, MIN_GAP);
            end
        end
        vectors++;
        if (total_st != MIN_GAP - 1) begin
            miscompares++; $display("FAIL b2b_ready_low: got %0d stall cycles exp %0d", total_st, MIN_GAP - 1);
        end
`ifdef KEY_EXTRACT_STAT_EN
        vectors++;
        if (key_cnt - kc0 !== 32'd3) begin miscompares++; $display("FAIL stat_key_cnt: got %0d exp 3", key_cnt - kc0); end
        vectors++;
        if (stall_cnt - sc0 !== 32'(MIN_GAP - 1)) begin
            miscompares++; $display("FAIL stat_stall_cnt: got %0d exp %0d", stall_cnt - sc0, MIN_GAP - 1);
        end
`endif
    endtask

    task automatic test_cfg_collision();
        logic [127:0] e_new;
        logic [PHV_LEN-1:0] pa, pb;
        logic ok, a, s;
        int st;
        idle(6);
        e_new = shadow[3];
        e_new[2:0] = 3'd1;
        pa = rand_phv(4'd3);
        pb = rand_phv(4'd3);
        send(pa, ok, st);
        step(1'b0, '0, 1'b1, 4'd3, e_new, a, s);
        vectors++;
        if (key_valid !== 1'b1) begin miscompares++; $display("FAIL coll_fire: key_valid got %b exp 1", key_valid); end
        vectors++;
        if (extract_key[196:149] !== get48(pa, 2)) begin
            miscompares++; $display("FAIL coll_old_entry: got %h exp %h", extract_key[196:149], get48(pa, 2));
        end
        send(pb, ok, st);
        wait_kv(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL coll_timeout: got no key_valid exp key_valid"); end
        vectors++;
        if (extract_key[196:149] !== get48(pb, 1)) begin
            miscompares++; $display("FAIL coll_new_entry: got %h exp %h", extract_key[196:149], get48(pb, 1));
        end
        idle(1);
    endtask

    task automatic test_reset_midop();
        logic [PHV_LEN-1:0] p1, p2, p3;
        logic [KEY_LEN-1:0] k;
        logic ok;
        int st;
        idle(6);
        p1 = rand_phv(4'd3);
        p2 = rand_phv(4'd3);
        send(p1, ok, st);
        send(p2, ok, st);
        idle(1);
        apply_reset();
        vectors++;
        if (key_valid !== 1'b0 || extract_key !== '0 || phv_out !== '0) begin
            miscompares++; $display("FAIL mid_rst_outputs: key_valid %b key %h exp 0 0", key_valid, extract_key);
        end
        vectors++;
        if (phv_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready: got %b exp 1", phv_ready); end
`ifdef KEY_EXTRACT_STAT_EN
        vectors++;
        if (key_cnt !== '0 || stall_cnt !== '0) begin
            miscompares++; $display("FAIL mid_rst_stats: got %0d/%0d exp 0/0", key_cnt, stall_cnt);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        p3 = rand_phv(4'd3);
        k = {get48(p3, 0), get48(p3, 0), get32(p3, 0), get32(p3, 0), get16(p3, 0), get16(p3, 0), 5'b0};
        send(p3, ok, st);
        vectors++;
        if (!ok || st != 0) begin miscompares++; $display("FAIL mid_accept: got stalls %0d exp 0", st); end
        idle(1);
        vectors++;
        if (key_valid !== 1'b1) begin miscompares++; $display("FAIL mid_latency: key_valid got %b exp 1", key_valid); end
        vectors++;
        if (extract_key !== k) begin miscompares++; $display("FAIL mid_table_zero: got %h exp %h", extract_key, k); end
        idle(3);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        test_reset();
        test_basic();
        test_select();
        test_conditions();
        test_back_to_back();
        test_cfg_collision();
        test_reset_midop();
        vectors++;
        if (exp_key_q.size() != 0) begin
            miscompares++; $display("FAIL sb_drain: got %0d pending exp 0", exp_key_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_extractor.md
Name: key_extractor

Overview:
- Per-stage key extractor. Sits directly upstream of the stage lookup engine and feeds it a 197b match key, a key_valid pulse, and the PHV.
- Selects two 48b, two 32b and two 16b PHV containers and computes 5 condition bits, all per a 16-entry program table indexed by the PHV program id.
- Buffers one PHV and enforces a minimum spacing between key_valid pulses, because the lookup engine has no back-pressure and is busy for 4 cycles per key.

Parameters:
- STAGE, 0, stage index; informational only.
- PHV_LEN, 1124, PHV width (8x48 + 8x32 + 8x16 + 100 + 256).
- KEY_LEN, 197, key width; fixed at 2x48 + 2x32 + 2x16 + 5.
- MIN_GAP, 4, minimum cycles between key_valid pulses; must be >= 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- phv_in  in  PHV_LEN  incoming PHV
- phv_valid  in  1  phv_in valid
- phv_ready  out  1  block can accept phv_in this cycle
- extract_key  out  KEY_LEN  match key to lookup engine
- key_valid  out  1  one-cycle pulse, key/PHV valid
- phv_out  out  PHV_LEN  PHV accompanying the key
- cfg_en  in  1  program table write strobe
- cfg_addr  in  4  table entry to write
- cfg_din  in  128  entry data

Behaviour:
- PHV layout, index 0 at the MSB end of each region:
  - 48b container i = phv_in[PHV_LEN-1-48*i -: 48].
  - 32b container i = phv_in[PHV_LEN-385-32*i -: 32].
  - 16b container i = phv_in[PHV_LEN-641-16*i -: 16].
  - prog_id = phv_in[3:0].
- Table entry layout:
  - [2:0] 48a, [5:3] 48b, [8:6] 32a, [11:9] 32b, [14:12] 16a, [17:15] 16b.
  - Condition i (0..4) is at [18+22*i +: 22]: [21] en, [20:19] op (00 eq, 01 gt, 10 lt, 11 ne), [18:16] 16b container index, [15:0] unsigned immediate.
- Key = {c48[48a], c48[48b], c32[32a], c32[32b], c16[16a], c16[16b], cond[4:0]}. Condition i drives key bit i. A disabled condition gives 0.
- Table: 16 x 128 flops, reset to all zero.
  - A write lands at the clock edge.
  - A fire on the same edge reads the pre-write contents.
- Input buffer: one entry (buf, buf_valid).
  - Accept when phv_valid && phv_ready.
  - phv_ready = !buf_valid || fire (combinational).
- Fire:
  - fire = buf_valid && gap_cnt == 0.
  - On a fire edge: extract_key and phv_out are registered from buf plus table[buf prog_id]; key_valid <= 1; gap_cnt <= MIN_GAP-1.
  - If a new PHV is accepted on the same edge, it replaces buf.
  - Otherwise buf_valid <= 0.
- gap_cnt decrements by 1 each cycle while nonzero and there is no fire.
- key_valid is high exactly one cycle per fire, otherwise 0.
- extract_key and phv_out hold until the next fire, so the lookup engine can sample them in later cycles.
- Latency: accept at edge N with gap_cnt == 0 gives key_valid high in cycle N+1..N+2.
- Throughput: one key per MIN_GAP cycles. A PHV waiting in buf holds phv_ready low until its fire cycle.
- Reset, including mid-operation: key_valid 0, extract_key 0, phv_out 0, buf_valid 0, gap_cnt 0, table cleared. phv_ready is 1 while buf is empty. Pending PHVs are discarded.

Optional Feature:
- Macro KEY_EXTRACT_STAT_EN.
- When defined: adds outputs key_cnt[31:0] (increments on each fire) and stall_cnt[31:0] (increments each cycle phv_valid && !phv_ready).
  - Both wrap at 2^32 and reset to 0.
- When undefined: neither port nor counter exists. Behaviour is otherwise identical.

Test Plan:
1. After reset, table zero; PHV prog_id 0 with c48[0]=0x112233445566, c32[0]=0xAABBCCDD, c16[0]=0x0800, accepted edge N -> key_valid cycle N+1 only; key = {0x112233445566 x2, 0xAABBCCDD x2, 0x0800 x2, 5'b0}; phv_out equals input.
2. Write entry 3: 48a=2, 16b=5, cond0 {en=1, op=eq, idx=1, imm=0x0800}. PHV prog_id 3 with c16[1]=0x0800 -> key bit0=1, key field 48a = c48[2], field 16b = c16[5].
3. Conditions on entry 4 with container=0x0100, imm=0x0100: cond0..3 = eq/gt/lt/ne -> key[3:0]=4'b0001; cond4 disabled -> bit4=0.
4. phv_valid held high with 3 distinct PHVs, MIN_GAP=4 -> key_valid at cycles t, t+4, t+8; keys in input order; phv_ready low while buffered PHV waits.
5. cfg write to entry 3 on the same edge as a prog_id 3 fire -> that key uses old entry; next prog_id 3 key uses new entry.
6. rst_n low during gap (gap_cnt=2), release, PHV accepted at edge N -> key_valid at N+1, no residual gap, table zeroed; stats counters 0 when KEY_EXTRACT_STAT_EN.
